// File: rtl/lsu_unit.sv
// Load/store unit: accepts one memory request at a time and runs it to completion over a
// simple req/ack data bus, with sign/zero extension for loads and byte-enable or RMW stores.
module lsu_unit #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter bit USE_BYTE_EN = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [2:0]          req_funct3,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic                bus_req,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_be,
    input  logic                bus_ack,
    input  logic [DATA_W-1:0]   bus_rdata,
    output logic [2:0]          dbg_state
);

    localparam int NB = DATA_W / 8;
    localparam int K  = $clog2(NB);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_RMW_RD = 3'd2,
        S_WR     = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t state, state_n;

    // Handshake: a request transfers on a rising edge where req_valid && req_ready; the
    // bus holds bus_req and its payload stable until the edge that samples bus_ack high.
    logic accept;
    logic ack_q;

    assign req_ready = (state == S_IDLE);
    assign accept    = req_valid && req_ready;
    assign ack_q     = bus_ack && bus_req;
    assign dbg_state = state;

    function automatic logic [NB-1:0] lane_be(input logic [K-1:0] off, input logic [1:0] size);
        logic [NB-1:0] m;
        for (int i = 0; i < NB; i++)
            m[i] = (i >= int'(off)) && (i < int'(off) + (1 << size));
        return m;
    endfunction

    function automatic logic [DATA_W-1:0] expand(input logic [NB-1:0] be);
        logic [DATA_W-1:0] m;
        for (int i = 0; i < NB; i++)
            m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

    function automatic logic [DATA_W-1:0] place_data(input logic [DATA_W-1:0] wdata,
                                                     input logic [K-1:0] off,
                                                     input logic [1:0] size);
        return (wdata & expand(lane_be('0, size))) << {off, 3'b000};
    endfunction

    logic [1:0]   dec_size;
    logic [K-1:0] dec_off;
    logic         dec_illegal;
    logic         dec_misal;
    logic         dec_err;

    always_comb begin
        dec_size = req_funct3[1:0];
        dec_off  = req_addr[K-1:0];
        if (req_we)
            dec_illegal = req_funct3[2] || (DATA_W == 32 && req_funct3[1:0] == 2'b11);
        else
            dec_illegal = (req_funct3 == 3'b111) ||
                          (DATA_W == 32 && (req_funct3 == 3'b011 || req_funct3 == 3'b110));
        case (dec_size)
            2'd1:    dec_misal = req_addr[0];
            2'd2:    dec_misal = |req_addr[1:0];
            2'd3:    dec_misal = |req_addr[2:0];
            default: dec_misal = 1'b0;
        endcase
        dec_err = dec_illegal || dec_misal;
    end

    logic [2:0]        r_funct3;
    logic [K-1:0]      r_off;
    logic [DATA_W-1:0] r_wdata;

    // Load path: shift the addressed field down, then zero-fill or replicate its MSB.
    logic [DATA_W-1:0] ld_shift;
    logic [DATA_W-1:0] ld_mask;
    logic [DATA_W-1:0] ld_ext;
    logic              ld_sign;

    always_comb begin
        ld_shift = bus_rdata >> {r_off, 3'b000};
        ld_mask  = expand(lane_be('0, r_funct3[1:0]));
        case (r_funct3[1:0])
            2'd0:    ld_sign = ld_shift[7];
            2'd1:    ld_sign = ld_shift[15];
            2'd2:    ld_sign = ld_shift[31];
            default: ld_sign = ld_shift[DATA_W-1];
        endcase
        ld_ext = ld_shift & ld_mask;
        if (!r_funct3[2] && ld_sign)
            ld_ext = ld_ext | ~ld_mask;
    end

    logic [DATA_W-1:0] rmw_data;

    always_comb begin
        rmw_data = (bus_rdata & ~expand(lane_be(r_off, r_funct3[1:0]))) |
                   place_data(r_wdata, r_off, r_funct3[1:0]);
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (dec_err)
                        state_n = S_RESP;
                    else if (!req_we)
                        state_n = S_RD;
                    else if (USE_BYTE_EN || int'(dec_size) == K)
                        state_n = S_WR;
                    else
                        state_n = S_RMW_RD;
                end
            end
            S_RD:     if (ack_q) state_n = S_RESP;
            S_RMW_RD: if (ack_q) state_n = S_WR;
            S_WR:     if (ack_q) state_n = S_RESP;
            S_RESP:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_be     <= '0;
            r_funct3   <= '0;
            r_off      <= '0;
            r_wdata    <= '0;
        end else begin
            state      <= state_n;
            resp_valid <= (state_n == S_RESP);
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        r_funct3 <= req_funct3;
                        r_off    <= dec_off;
                        r_wdata  <= req_wdata;
                        if (dec_err) begin
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            bus_req  <= 1'b1;
                            bus_addr <= {req_addr[ADDR_W-1:K], {K{1'b0}}};
                            bus_we   <= (state_n == S_WR);
                            if (state_n == S_WR) begin
                                bus_be    <= lane_be(dec_off, dec_size);
                                bus_wdata <= place_data(req_wdata, dec_off, dec_size);
                            end else begin
                                bus_be    <= '1;
                                bus_wdata <= '0;
                            end
                        end
                    end
                end
                S_RD: begin
                    if (ack_q) begin
                        bus_req    <= 1'b0;
                        resp_rdata <= ld_ext;
                        resp_err   <= 1'b0;
                    end
                end
                S_RMW_RD: begin
                    // bus_req stays high: the merged write follows the read directly.
                    if (ack_q) begin
                        bus_we    <= 1'b1;
                        bus_wdata <= rmw_data;
                    end
                end
                S_WR: begin
                    if (ack_q) begin
                        bus_req    <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_unit.sv
// Bench for lsu_unit: unit 0 is 32-bit with byte enables, unit 1 is 64-bit with RMW stores;
// a transaction-level model predicts every cycle of bus and response activity.
`timescale 1ns/1ps
module tb_lsu_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic        req_valid[2];
    logic        req_we[2];
    logic [2:0]  req_funct3[2];
    logic [31:0] req_addr[2];
    logic [63:0] req_wdata[2];
    logic        bus_ack[2];
    logic [63:0] bus_rdata[2];

    logic        o_ready[2], o_valid[2], o_err[2], o_bus_req[2], o_bus_we[2];
    logic [31:0] o_addr[2];
    logic [63:0] o_rdata[2], o_wdata[2];
    logic [7:0]  o_be[2];

    logic [31:0] a_rdata, a_wdata;
    logic [3:0]  a_be;
    logic [63:0] b_rdata, b_wdata;
    logic [7:0]  b_be;
    logic [2:0]  a_dbg, b_dbg;

    assign o_rdata[0] = {32'b0, a_rdata};
    assign o_wdata[0] = {32'b0, a_wdata};
    assign o_be[0]    = {4'b0, a_be};
    assign o_rdata[1] = b_rdata;
    assign o_wdata[1] = b_wdata;
    assign o_be[1]    = b_be;

    lsu_unit #(.DATA_W(32), .ADDR_W(32), .USE_BYTE_EN(1'b1)) u_a (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(o_ready[0]), .req_we(req_we[0]),
        .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0][31:0]),
        .resp_valid(o_valid[0]), .resp_rdata(a_rdata), .resp_err(o_err[0]),
        .bus_req(o_bus_req[0]), .bus_we(o_bus_we[0]), .bus_addr(o_addr[0]),
        .bus_wdata(a_wdata), .bus_be(a_be), .bus_ack(bus_ack[0]),
        .bus_rdata(bus_rdata[0][31:0]), .dbg_state(a_dbg)
    );

    lsu_unit #(.DATA_W(64), .ADDR_W(32), .USE_BYTE_EN(1'b0)) u_b (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(o_ready[1]), .req_we(req_we[1]),
        .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(o_valid[1]), .resp_rdata(b_rdata), .resp_err(o_err[1]),
        .bus_req(o_bus_req[1]), .bus_we(o_bus_we[1]), .bus_addr(o_addr[1]),
        .bus_wdata(b_wdata), .bus_be(b_be), .bus_ack(bus_ack[1]),
        .bus_rdata(bus_rdata[1]), .dbg_state(b_dbg)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic        e_ready[2], e_bus_req[2], e_we[2], e_valid[2], e_err[2];
    logic [31:0] e_addr[2];
    logic [63:0] e_wdata[2], e_rdata[2];
    logic [7:0]  e_be[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            for (int u = 0; u < 2; u++) begin
                chk($sformatf("u%0d req_ready", u), 64'(o_ready[u]), 64'(e_ready[u]));
                chk($sformatf("u%0d bus_req", u), 64'(o_bus_req[u]), 64'(e_bus_req[u]));
                if (e_bus_req[u]) begin
                    chk($sformatf("u%0d bus_we", u), 64'(o_bus_we[u]), 64'(e_we[u]));
                    chk($sformatf("u%0d bus_addr", u), 64'(o_addr[u]), 64'(e_addr[u]));
                    chk($sformatf("u%0d bus_be", u), 64'(o_be[u]), 64'(e_be[u]));
                    if (e_we[u])
                        chk($sformatf("u%0d bus_wdata", u), o_wdata[u], e_wdata[u]);
                end
                chk($sformatf("u%0d resp_valid", u), 64'(o_valid[u]), 64'(e_valid[u]));
                if (e_valid[u]) begin
                    chk($sformatf("u%0d resp_err", u), 64'(o_err[u]), 64'(e_err[u]));
                    chk($sformatf("u%0d resp_rdata", u), o_rdata[u], e_rdata[u]);
                end
            end
        end
    end

    task automatic set_idle(input int u);
        e_ready[u]   = 1'b1;
        e_bus_req[u] = 1'b0;
        e_valid[u]   = 1'b0;
    endtask

    task automatic idle(input int u, input int n);
        for (int i = 0; i < n; i++) begin
            set_idle(u);
            bus_ack[u]   = ($urandom_range(0, 3) == 0);
            bus_rdata[u] = {$urandom, $urandom};
            @(posedge clk); #1;
            bus_ack[u] = 1'b0;
        end
    endtask

    // One request end to end; the model derives every bus phase and the response from
    // the access width, offset and signedness encoded in funct3.
    task automatic run_req(input int u, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [63:0] wdata,
                           input logic [63:0] rd_fix, input bit fix, input int wait_fix,
                           output logic [63:0] m_rdata, output logic [63:0] m_wdata);
        int dw, nb, off, nw, nph;
        bit legal, err, rmw, is_wr;
        logic [63:0] dmask, fmask, rd, v;
        logic [7:0]  be, all;
        dw    = (u == 0) ? 32 : 64;
        dmask = (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
        all   = (dw == 64) ? 8'hFF : 8'h0F;
        nb    = 1 << f3[1:0];
        if (we) legal = (f3 < 3'd4) && !(f3 == 3'd3 && dw == 32);
        else    legal = (f3 != 3'd7) && !(dw == 32 && (f3 == 3'd3 || f3 == 3'd6));
        err   = !legal || (addr % nb != 0);
        off   = addr % (dw / 8);
        fmask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
        be    = 8'(((1 << nb) - 1) << off);
        rmw   = we && (u == 1) && (nb * 8 < dw);
        rd    = (fix ? rd_fix : {$urandom, $urandom}) & dmask;
        m_wdata = ((wdata & fmask) << (8 * off)) & dmask;
        if (rmw)
            for (int i = 0; i < 8; i++)
                if (!be[i]) m_wdata[8*i +: 8] = rd[8*i +: 8];
        m_rdata = 64'd0;
        if (!we && !err) begin
            v = (rd >> (8 * off)) & fmask;
            if (!f3[2] && v[8*nb-1]) v = v | ~fmask;
            m_rdata = v & dmask;
        end

        set_idle(u);
        req_valid[u] = 1'b1; req_we[u] = we; req_funct3[u] = f3;
        req_addr[u] = addr; req_wdata[u] = wdata;
        @(posedge clk); #1;
        req_valid[u] = 1'b0;

        if (!err) begin
            nph = rmw ? 2 : 1;
            for (int ph = 0; ph < nph; ph++) begin
                is_wr = we && !(rmw && ph == 0);
                nw = (wait_fix >= 0) ? wait_fix : $urandom_range(0, 3);
                for (int w = 0; w <= nw; w++) begin
                    e_ready[u] = 1'b0; e_bus_req[u] = 1'b1; e_valid[u] = 1'b0;
                    e_we[u]    = is_wr;
                    e_addr[u]  = addr & ~(32'(dw / 8) - 32'd1);
                    e_be[u]    = (is_wr && !rmw) ? be : all;
                    e_wdata[u] = m_wdata;
                    bus_ack[u]   = (w == nw);
                    bus_rdata[u] = (w == nw) ? rd : ({$urandom, $urandom} & dmask);
                    @(posedge clk); #1;
                    bus_ack[u] = 1'b0;
                end
            end
        end
        e_ready[u] = 1'b0; e_bus_req[u] = 1'b0; e_valid[u] = 1'b1;
        e_err[u] = err; e_rdata[u] = m_rdata;
        @(posedge clk); #1;
        set_idle(u);
    endtask

    logic [63:0] mr, mw;
    logic [31:0] ra;
    logic [2:0]  rf;
    int          ru;

    initial begin
        reset = 1'b1;
        for (int u = 0; u < 2; u++) begin
            req_valid[u] = 0; req_we[u] = 0; req_funct3[u] = 0; req_addr[u] = 0;
            req_wdata[u] = 0; bus_ack[u] = 0; bus_rdata[u] = 0;
            set_idle(u); e_we[u] = 0; e_err[u] = 0; e_addr[u] = 0;
            e_wdata[u] = 0; e_rdata[u] = 0; e_be[u] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            chk("reset req_ready", 64'(o_ready[u]), 64'd1);
            chk("reset resp_valid", 64'(o_valid[u]), 64'd0);
            chk("reset resp_rdata", o_rdata[u], 64'd0);
            chk("reset resp_err", 64'(o_err[u]), 64'd0);
            chk("reset bus_req", 64'(o_bus_req[u]), 64'd0);
            chk("reset bus_we", 64'(o_bus_we[u]), 64'd0);
            chk("reset bus_addr", 64'(o_addr[u]), 64'd0);
            chk("reset bus_wdata", o_wdata[u], 64'd0);
            chk("reset bus_be", 64'(o_be[u]), 64'd0);
        end
        reset = 1'b0;
        chk_en = 1'b1;
        idle(0, 2);

        run_req(0, 0, 3'b000, 32'h1003, 64'd0, 64'h80F0_7F01, 1, 0, mr, mw);
        chk("model LB", mr, 64'h0000_0000_FFFF_FF80);
        run_req(0, 0, 3'b100, 32'h1002, 64'd0, 64'h80F0_7F01, 1, 0, mr, mw);
        chk("model LBU", mr, 64'h0000_00F0);
        run_req(0, 0, 3'b001, 32'h2002, 64'd0, 64'h8001_1234, 1, 0, mr, mw);
        chk("model LH", mr, 64'h0000_0000_FFFF_8001);
        run_req(0, 0, 3'b101, 32'h2002, 64'd0, 64'h8001_1234, 1, 1, mr, mw);
        chk("model LHU", mr, 64'h0000_8001);
        run_req(0, 1, 3'b000, 32'h11, 64'hAB, 64'd0, 1, 0, mr, mw);
        chk("model SB lanes", mw, 64'h0000_AB00);
        run_req(0, 0, 3'b010, 32'h6, 64'd0, 64'd0, 1, 0, mr, mw);
        run_req(0, 0, 3'b111, 32'h0, 64'd0, 64'd0, 1, 0, mr, mw);
        run_req(0, 0, 3'b010, 32'h100, 64'd0, 64'hCAFE_F00D, 1, 4, mr, mw);
        chk("model LW", mr, 64'hCAFE_F00D);
        idle(0, 1);

        run_req(1, 1, 3'b000, 32'h13, 64'h5A, 64'h1122_3344, 1, 0, mr, mw);
        chk("model SB rmw", mw, 64'h5A22_3344);

        // Abandon an RMW store while its read is outstanding.
        req_valid[1] = 1; req_we[1] = 1; req_funct3[1] = 3'b000;
        req_addr[1] = 32'h21; req_wdata[1] = 64'h77;
        @(posedge clk); #1;
        req_valid[1] = 0;
        e_ready[1] = 0; e_bus_req[1] = 1; e_we[1] = 0; e_addr[1] = 32'h20; e_be[1] = 8'hFF;
        #2 reset = 1'b1;
        #1;
        chk("reset mid-op bus_req", 64'(o_bus_req[1]), 64'd0);
        chk("reset mid-op resp_valid", 64'(o_valid[1]), 64'd0);
        set_idle(1);
        @(posedge clk); #1;
        reset = 1'b0;
        bus_ack[1] = 1'b1; bus_rdata[1] = 64'hDEAD_BEEF;
        @(posedge clk); #1;
        bus_ack[1] = 1'b0;
        idle(1, 2);
        run_req(1, 0, 3'b010, 32'h40, 64'd0, 64'h0000_0001_8765_4321, 1, 1, mr, mw);
        chk("model LW 64", mr, 64'hFFFF_FFFF_8765_4321);
        run_req(1, 0, 3'b011, 32'h8, 64'd0, 64'h0123_4567_89AB_CDEF, 1, 0, mr, mw);
        chk("model LD", mr, 64'h0123_4567_89AB_CDEF);
        run_req(1, 0, 3'b110, 32'hC, 64'd0, 64'h8000_0000_1234_5678, 1, 0, mr, mw);
        chk("model LWU", mr, 64'h0000_0000_8000_0000);
        run_req(1, 1, 3'b011, 32'h18, 64'h1122_3344_5566_7788, 64'd0, 1, 0, mr, mw);

        for (int n = 0; n < 300; n++) begin
            ru = $urandom_range(0, 1);
            rf = 3'($urandom_range(0, 7));
            ra = $urandom & 32'h0000_FFFF;
            if ($urandom_range(0, 3) != 0)
                ra = ra & ~(32'(1 << rf[1:0]) - 32'd1);
            run_req(ru, 1'($urandom_range(0, 1)), rf, ra, {$urandom, $urandom},
                    64'd0, 0, -1, mr, mw);
            idle(ru, $urandom_range(0, 2));
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_unit.md
# lsu_unit

Parametrised load/store unit between the RV32I/RV64I core datapath and the data bus. It accepts one memory request at a time from the execute stage and runs it to completion through a small FSM. Each request is a load or store of byte, half, word or (64-bit only) double width. It produces one sign- or zero-extended load result per request, or an error flag for misaligned or illegal requests. Sub-word stores are performed either with byte enables or with a bus read-modify-write, selected at build time.

## Interface
- DATA_W, 32: data path and bus width; legal values 32 or 64.
- ADDR_W, 32: address width.
- USE_BYTE_EN, 1: 1 = sub-word stores use a single write with bus_be strobes; 0 = sub-word stores use read-modify-write with bus_be all ones.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 width/sign code.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-aligned.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned address or illegal funct3; qualified by resp_valid.
- bus_req  out  1  bus transaction request.
- bus_we  out  1  bus write.
- bus_addr  out  ADDR_W  req_addr with the low log2(DATA_W/8) bits cleared.
- bus_wdata  out  DATA_W  write data.
- bus_be  out  DATA_W/8  byte lane enables.
- bus_ack  in  1  one-cycle completion; read data valid in the same cycle.
- bus_rdata  in  DATA_W  read data.

## Operation
- FSM states: IDLE, RD, RMW_RD, WR, RESP.
- Acceptance: a request is accepted on a rising edge where req_valid && req_ready. funct3, addr and wdata are registered at that edge.
- IDLE transitions on accept:
  - error → RESP
  - load → RD
  - store, USE_BYTE_EN=1 or full-width → WR
  - store, USE_BYTE_EN=0 and sub-word → RMW_RD
- RD on bus_ack: capture the extended data, then → RESP.
- RMW_RD on bus_ack: merge the store bytes into bus_rdata, register the result as bus_wdata, then → WR.
- WR on bus_ack → RESP.
- RESP: resp_valid=1 for exactly one cycle, then → IDLE.
- Load funct3 encoding:
  - 000 LB, 100 LBU: byte at offset addr[k-1:0], where k = log2(DATA_W/8).
  - 001 LH, 101 LHU: half-word.
  - 010 LW: word.
  - 110 LWU, 011 LD: DATA_W=64 only.
  - Signed loads replicate the MSB of the selected field; unsigned loads zero-fill.
- Store funct3 encoding: 000 SB, 001 SH, 010 SW, 011 SD (DATA_W=64 only).
- Errors:
  - illegal funct3: 111; 011/110 when DATA_W=32; store funct3 >= 100.
  - misaligned: half with addr[0]!=0, word with addr[1:0]!=0, double with addr[2:0]!=0.
  - An error issues no bus transaction and gives resp_err=1, resp_rdata=0.
- Byte-enable mode writes:
  - store data is shifted into lane position addr offset × 8.
  - unselected lanes of bus_wdata are 0.
  - bus_be has exactly size-many bits set, starting at the offset.
- Loads and RMW reads drive bus_be all ones and bus_we=0.
- resp_rdata holds its value until the next response.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_be=0.
- All bus_* and resp_* outputs are registered; req_ready is decoded from state.
- bus_req rises in the cycle after the accept edge (or after the RMW_RD→WR edge). It stays high with stable addr/we/wdata/be until the edge at which bus_ack=1 is sampled, then falls.
- bus_ack while bus_req=0 is ignored.
- Latency from the accept edge to resp_valid, with zero wait states (ack in the first bus_req cycle):
  - load: 2 cycles
  - store, byte-enable or full-width: 2 cycles
  - RMW store: 3 cycles
  - error: 1 cycle
- Each bus wait state adds 1 cycle.
- Back-to-back: req_ready returns high in the cycle after resp_valid. Maximum throughput is one request per 3 cycles.
- Reset asserted mid-operation: bus_req drops immediately (asynchronously), the transaction is abandoned and no response is produced. Any bus_ack arriving after reset release is ignored.

## Test plan
- LB sign-extension: DATA_W=32, bus_rdata=0x80F0_7F01, addr 0x1003 → resp_rdata 0xFFFF_FF80. Same data with LBU at 0x1002 → 0x0000_00F0.
- LH/LHU: addr 0x2002, bus_rdata=0x8001_1234 → LH gives 0xFFFF_8001, LHU gives 0x0000_8001. bus_addr=0x2000 in both cases.
- SB, USE_BYTE_EN=1: addr 0x11, wdata 0xAB → bus_be=0010, bus_wdata=0x0000_AB00, single write, resp_valid 2 cycles after accept.
- SB, USE_BYTE_EN=0: addr 0x13, wdata 0x5A, read returns 0x1122_3344 → write data 0x5A22_3344 with bus_be=1111, resp_valid 3 cycles after accept.
- Errors: LW at addr 0x6 → resp_err=1 one cycle after accept with no bus_req; funct3 111 → resp_err=1. Hold bus_ack low 4 cycles on a load → bus outputs stable throughout, resp_valid 6 cycles after accept.
- Reset mid-RMW (in RMW_RD): bus_req=0 at once, no resp_valid; a fresh LW afterwards completes normally.
- DATA_W=64: LD at 0x8 → full 64-bit data returned; LWU at 0xC, upper word 0x8000_0000 → 0x0000_0000_8000_0000.
